multibyte_sub_sequencer: RTL
============================

Name: multibyte_sub_sequencer

Overview:
Sequencer that sits directly upstream of the byte-wide borrow-chain subtractor and consumes its results. It accepts two NUM_BYTES-wide operands on a start/done handshake and issues them one byte per transaction, LSB byte first. It chains each byte's borrow-out into the next byte's borrow-in, assembles the full difference, and reports the final borrow.

Parameters:
DATA_WIDTH, 8, bits per byte slice handed to the byte subtractor
NUM_BYTES, 4, number of byte slices per operand (>=1)
TIMEOUT_CYCLES, 16, max cycles to wait for sub_done (used only with the optional feature)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  NUM_BYTES*DATA_WIDTH  minuend
b  input  NUM_BYTES*DATA_WIDTH  subtrahend
borrow_in  input  1  borrow into byte 0
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
diff  output  NUM_BYTES*DATA_WIDTH  assembled a-b-borrow_in
borrow_out  output  1  borrow out of the top byte
error  output  1  timeout flag; tied 0 without the optional feature
sub_a  output  DATA_WIDTH  byte A to the subtractor
sub_b  output  DATA_WIDTH  byte B to the subtractor
sub_borrow_in  output  1  borrow to the subtractor
sub_start  output  1  one-cycle issue pulse to the subtractor
sub_diff  input  DATA_WIDTH  byte result
sub_borrow_out  input  1  byte borrow result
sub_done  input  1  byte result valid, single-cycle pulse

Behaviour:
- Reset values: all outputs 0, state IDLE, byte index 0, internal operand registers 0.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE, start=1: capture a, b and borrow_in into registers; index<=0; go to ISSUE.
- ISSUE (exactly one cycle):
  - sub_start=1.
  - sub_a/sub_b = captured byte[index].
  - sub_borrow_in = running borrow (borrow_in for index 0).
  - Go to WAIT.
- sub_a, sub_b and sub_borrow_in are registered and held stable from ISSUE through WAIT until sub_done.
- WAIT, sub_done=1:
  - Write sub_diff into diff byte[index]; running borrow <= sub_borrow_out.
  - If index==NUM_BYTES-1: go to FIN.
  - Otherwise: index++ and go to ISSUE.
- sub_done arrives no earlier than the cycle after sub_start. A sub_done seen in IDLE, ISSUE or FIN is ignored.
- FIN: done=1 for one cycle; borrow_out <= final borrow; return to IDLE.
- busy=1 in ISSUE and WAIT, 0 in IDLE and FIN.
- Latency with a 1-cycle subtractor: done asserts 2*NUM_BYTES+1 cycles after the start cycle (9 for defaults).
- diff and borrow_out hold their values until the next accepted start.
  - diff bytes update incrementally during an operation; diff is valid only when done is high or afterwards.
- start while busy or in FIN: ignored, not queued. Operand changes after capture have no effect.
- Arithmetic: modulo 2^(NUM_BYTES*DATA_WIDTH). borrow_out=1 iff a < b + borrow_in (unsigned).
- NUM_BYTES=1: one ISSUE/WAIT pass, then FIN.
- reset mid-operation: immediately IDLE, all outputs 0, sub_start=0. Any in-flight sub_done after reset is ignored.

Optional Feature:
SUB_TIMEOUT_EN
- With the macro:
  - A wait counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without sub_done: go to FIN, assert done with error=1 and borrow_out=0; diff holds partial bytes.
  - error holds until the next accepted start or reset.
  - sub_done on the same cycle the limit is reached wins (no error).
- Without the macro: no counter, WAIT waits indefinitely, and error is constant 0.

Test Plan:
1. a=0x12345678, b=0x00000001, borrow_in=0, 1-cycle responder -> diff=0x12345677, borrow_out=0, done 9 cycles after start.
2. a=0x00000000, b=0x00000001, borrow_in=0 -> diff=0xFFFFFFFF, borrow_out=1; sub_borrow_in=1 on issues 1-3.
3. a=0x00000100, b=0x00000000, borrow_in=1 -> diff=0x000000FF, borrow_out=0.
4. Responder with 3-cycle sub_done delay; start pulsed again while busy; a changed mid-operation -> single done, result from the captured operands only, sub_a/sub_b stable through each WAIT.
5. reset asserted during WAIT of byte 2, then a stray sub_done -> all outputs 0, state IDLE, no done; a subsequent start runs correctly.
6. SUB_TIMEOUT_EN, TIMEOUT_CYCLES=16, responder never answers byte 1 -> done and error=1 exactly 16 WAIT cycles after that issue. Without the macro -> busy stays 1 and error=0.

Source files
------------

// File: rtl/multibyte_sub_sequencer.sv
// multibyte_sub_sequencer
//
// Runs a NUM_BYTES-wide subtraction by driving an external byte-wide
// borrow-chain subtractor. The operands are issued one byte at a time, LSB
// byte first. Each byte's borrow-out is fed back as the next byte's
// borrow-in. The full difference is assembled here, and the final borrow is
// reported at completion.
//
// Optional feature: define SUB_TIMEOUT_EN to bound each wait for sub_done to
// TIMEOUT_CYCLES. When the bound expires, the operation ends with done=1,
// error=1 and borrow_out=0, and diff keeps only the bytes already received.
// Without the macro, WAIT has no limit and error is tied to 0.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   start             operation request, sampled only while idle
//   a, b, borrow_in   minuend, subtrahend, borrow into byte 0
//   busy              high while bytes are being issued or awaited
//   done              one-cycle completion pulse
//   diff, borrow_out  assembled a-b-borrow_in and borrow out of the top byte
//   error             timeout flag (SUB_TIMEOUT_EN only)
//   sub_a, sub_b      byte operands to the subtractor, held until sub_done
//   sub_borrow_in     borrow into the current byte
//   sub_start         one-cycle issue pulse to the subtractor
//   sub_diff          byte result from the subtractor
//   sub_borrow_out    byte borrow result from the subtractor
//   sub_done          byte result valid (single-cycle pulse)
module multibyte_sub_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] a,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] b,
    input  logic                            borrow_in,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_BYTES*DATA_WIDTH-1:0] diff,
    output logic                            borrow_out,
    output logic                            error,
    output logic [DATA_WIDTH-1:0]           sub_a,
    output logic [DATA_WIDTH-1:0]           sub_b,
    output logic                            sub_borrow_in,
    output logic                            sub_start,
    input  logic [DATA_WIDTH-1:0]           sub_diff,
    input  logic                            sub_borrow_out,
    input  logic                            sub_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
    typedef logic [NUM_BYTES-1:0][DATA_WIDTH-1:0] word_t;

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
    word_t                 a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic                  bout_q, bout_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] sub_a_q, sub_a_d, sub_b_q, sub_b_d;
    logic                  sub_bin_q, sub_bin_d;
    logic                  sub_start_q, sub_start_d;
`ifdef SUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic                  err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            done_q      <= 1'b0;
            sub_a_q     <= '0;
            sub_b_q     <= '0;
            sub_bin_q   <= 1'b0;
            sub_start_q <= 1'b0;
`ifdef SUB_TIMEOUT_EN
            wcnt_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            done_q      <= done_d;
            sub_a_q     <= sub_a_d;
            sub_b_q     <= sub_b_d;
            sub_bin_q   <= sub_bin_d;
            sub_start_q <= sub_start_d;
`ifdef SUB_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // The subtractor-facing byte registers are loaded on the edge that enters
    // ISSUE. As a result, sub_start and its operands appear together in the
    // ISSUE cycle and stay put for the whole WAIT. The running borrow lives
    // in sub_bin_q.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idx_nxt     = idx_q + 1'b1;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        done_d      = 1'b0;
        sub_a_d     = sub_a_q;
        sub_b_d     = sub_b_q;
        sub_bin_d   = sub_bin_q;
        sub_start_d = 1'b0;
`ifdef SUB_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d         = a;
                    b_d         = b;
                    idx_d       = '0;
                    sub_a_d     = a[DATA_WIDTH-1:0];
                    sub_b_d     = b[DATA_WIDTH-1:0];
                    sub_bin_d   = borrow_in;
                    sub_start_d = 1'b1;
                    state_d     = ISSUE;
`ifdef SUB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SUB_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (sub_done) begin
                    diff_d[idx_q] = sub_diff;
                    if (idx_q == LAST_IDX) begin
                        bout_d  = sub_borrow_out;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d       = idx_nxt;
                        sub_a_d     = a_q[idx_nxt];
                        sub_b_d     = b_q[idx_nxt];
                        sub_bin_d   = sub_borrow_out;
                        sub_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
`ifdef SUB_TIMEOUT_EN
                // A sub_done in the limit cycle takes priority over the timeout.
                else if (wcnt_q == WAIT_LAST) begin
                    bout_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q == ISSUE) || (state_q == WAIT);
    assign done          = done_q;
    assign diff          = diff_q;
    assign borrow_out    = bout_q;
    assign sub_a         = sub_a_q;
    assign sub_b         = sub_b_q;
    assign sub_borrow_in = sub_bin_q;
    assign sub_start     = sub_start_q;
`ifdef SUB_TIMEOUT_EN
    assign error         = err_q;
`else
    assign error         = 1'b0;
`endif

endmodule
